// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry registered pipeline stage with a valid/ready
// handshake and a skid buffer. It sits between the operand/PC select muxes
// and the next RV32I stage.
//
// Every output comes straight from a flop, so the downstream stall has no
// combinational path back into the upstream mux-select logic. O_READY drops
// one cycle after the first stalled accept. The skid register holds the word
// that was accepted in that cycle.
//
// Optional feature: define PIPE_SKID_REG_PERF_CNT_EN to build a saturating
// 32-bit stall-cycle counter on O_STALL_CNT. Without the macro, O_STALL_CNT
// is tied to zero and no counter flops are built.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | no entry held; O_VALID=0, O_READY=1
// BUSY  | main register valid, skid free; O_VALID=1, O_READY=1
// FULL  | main and skid both valid; O_VALID=1, O_READY=0
module pipe_skid_reg #(
  parameter int DW = 32
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_FLUSH,
  input  logic          I_VALID,
  output logic          O_READY,
  input  logic [DW-1:0] I_DATA,
  output logic          O_VALID,
  input  logic          I_READY,
  output logic [DW-1:0] O_DATA,
  output logic [31:0]   O_STALL_CNT
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;

  logic acc;
  logic deq;
  logic main_ld_in;
  logic main_ld_skid;
  logic skid_ld;

  // Handshake qualifiers. They use registered outputs only, so no input
  // reaches an output within the same cycle.
  always_comb begin
    acc = I_VALID & ready_q;
    deq = valid_q & I_READY;
  end

  // Next-state and register-load decode. A flush overrides every transition
  // and suppresses loads. The data registers keep their old values because
  // their contents are don't-care once the matching entry is invalid.
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d    = ST_BUSY;
          main_ld_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (acc && deq) begin
          main_ld_in = 1'b1;
        end else if (acc) begin
          state_d = ST_FULL;
          skid_ld = 1'b1;
        end else if (deq) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deq) begin
          state_d      = ST_BUSY;
          main_ld_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (I_FLUSH) begin
      state_d      = ST_EMPTY;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  // Datapath muxes and output flags. The flags are precomputed from the next
  // state, so O_VALID and O_READY each leave directly from a flop.
  always_comb begin
    main_d = main_q;
    if (main_ld_skid) begin
      main_d = skid_q;
    end else if (main_ld_in) begin
      main_d = I_DATA;
    end

    skid_d = skid_q;
    if (skid_ld) begin
      skid_d = I_DATA;
    end

    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  // State and data registers. Reset empties the stage and zeroes both data
  // registers, and it takes priority over flush.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign O_VALID = valid_q;
  assign O_READY = ready_q;
  assign O_DATA  = main_q;

`ifdef PIPE_SKID_REG_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a word is offered downstream but not taken. The count
  // saturates instead of wrapping, and a flush wins over the increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (I_FLUSH) begin
      stall_cnt_d = '0;
    end else if (valid_q && !I_READY && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign O_STALL_CNT = stall_cnt_q;
`else
  assign O_STALL_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg. A queue-based FIFO model predicts the outputs, and
// a compare process checks the DUT against it on every falling edge.
// Directed steps add literal expectations that pin down the model.
module tb_pipe_skid_reg;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic        I_FLUSH;
  logic        I_VALID;
  logic        O_READY;
  logic [31:0] I_DATA;
  logic        O_VALID;
  logic        I_READY;
  logic [31:0] O_DATA;
  logic [31:0] O_STALL_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  logic [31:0] m_stall = 32'd0;

  pipe_skid_reg #(.DW(32)) dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_FLUSH    (I_FLUSH),
    .I_VALID    (I_VALID),
    .O_READY    (O_READY),
    .I_DATA     (I_DATA),
    .O_VALID    (O_VALID),
    .I_READY    (I_READY),
    .O_DATA     (O_DATA),
    .O_STALL_CNT(O_STALL_CNT)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of depth 2. Valid means non-empty and ready
  // means not full. Flush and reset empty it.
  always @(posedge I_CLK) begin
    bit m_valid, m_ready, acc, deq;
    m_valid = (mq.size() > 0);
    m_ready = (mq.size() < 2);
    acc = I_VALID && m_ready;
    deq = m_valid && I_READY;
    if (I_RST) begin
      mq.delete();
      m_stall = 32'd0;
    end else if (I_FLUSH) begin
      mq.delete();
      m_stall = 32'd0;
    end else begin
`ifdef PIPE_SKID_REG_PERF_CNT_EN
      if (m_valid && !I_READY && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(I_DATA);
    end
  end

  // Compare process: check the DUT against the model mid-cycle.
  always @(negedge I_CLK) begin
    if (chk_en) begin
      chk("m_valid", {31'd0, O_VALID}, {31'd0, mq.size() > 0});
      chk("m_ready", {31'd0, O_READY}, {31'd0, mq.size() < 2});
      if (mq.size() > 0) chk("m_data", O_DATA, mq[0]);
      chk("m_stall", O_STALL_CNT, m_stall);
    end
  end

  task automatic cyc(input logic rst, input logic flush, input logic v,
                     input logic [31:0] d, input logic rdy);
    I_RST   = rst;
    I_FLUSH = flush;
    I_VALID = v;
    I_DATA  = d;
    I_READY = rdy;
    @(posedge I_CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PIPE_SKID_REG_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    // 1. reset
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
    chk("rst_valid", {31'd0, O_VALID}, 32'd0);
    chk("rst_ready", {31'd0, O_READY}, 32'd1);
    chk("rst_data", O_DATA, 32'd0);
    chk("rst_cnt", O_STALL_CNT, 32'd0);

    // 2. streaming
    cyc(0, 0, 1, 32'h1, 1);
    chk("str1", O_DATA, 32'h1);
    chk("str1_v", {31'd0, O_VALID}, 32'd1);
    cyc(0, 0, 1, 32'h2, 1);
    chk("str2", O_DATA, 32'h2);
    cyc(0, 0, 1, 32'h3, 1);
    chk("str3", O_DATA, 32'h3);
    chk("str_ready", {31'd0, O_READY}, 32'd1);
    cyc(0, 0, 0, 32'h0, 1);
    chk("str_empty", {31'd0, O_VALID}, 32'd0);

    // 3. backpressure
    cyc(0, 0, 1, 32'hA, 0);
    chk("bp_a", O_DATA, 32'hA);
    chk("bp_a_rdy", {31'd0, O_READY}, 32'd1);
    cyc(0, 0, 1, 32'hB, 0);
    chk("bp_full_rdy", {31'd0, O_READY}, 32'd0);
    chk("bp_hold_a", O_DATA, 32'hA);
    cyc(0, 0, 1, 32'hC, 0);
    chk("bp_c_refused", O_DATA, 32'hA);
    cyc(0, 0, 1, 32'hC, 1);
    chk("bp_out_b", O_DATA, 32'hB);
    chk("bp_rdy_back", {31'd0, O_READY}, 32'd1);
    cyc(0, 0, 1, 32'hC, 1);
    chk("bp_out_c", O_DATA, 32'hC);
    cyc(0, 0, 0, 32'h0, 1);
    chk("bp_drained", {31'd0, O_VALID}, 32'd0);

    // 4. flush while FULL with a same-cycle offer
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    cyc(0, 1, 1, 32'hD, 0);
    chk("fl_valid", {31'd0, O_VALID}, 32'd0);
    chk("fl_ready", {31'd0, O_READY}, 32'd1);
    chk("fl_cnt", O_STALL_CNT, 32'd0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    chk("fl_no_d", {31'd0, O_VALID}, 32'd0);

    // 5. reset with flush while FULL
    cyc(0, 0, 1, 32'h11, 0);
    cyc(0, 0, 1, 32'h22, 0);
    cyc(1, 1, 1, 32'h33, 0);
    chk("rf_valid", {31'd0, O_VALID}, 32'd0);
    chk("rf_ready", {31'd0, O_READY}, 32'd1);
    chk("rf_data", O_DATA, 32'd0);

    // 6. stall counter
    cyc(0, 0, 1, 32'h5, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 0);
    chk("cnt5", O_STALL_CNT, exp_cnt(32'd5));
`ifdef PIPE_SKID_REG_PERF_CNT_EN
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    m_stall = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 0);
    chk("cnt_sat", O_STALL_CNT, exp_cnt(32'hFFFF_FFFF));
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 1);
    chk("cnt_flush", O_STALL_CNT, 32'd0);

    // Mixed traffic, checked by the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      cyc(0, ($urandom_range(0, 24) == 0), $urandom_range(0, 1), $urandom,
          ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);
    chk("end_empty", {31'd0, O_VALID}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
